answer_period_mp: RTL and testbench
===================================

// Module: answer_period_mp
// PURPOSE
//  Parametrised multi-player successor of the single-player answer window.
//  Started by answerSig; freezes player counters (stopCount) and shows a seconds countdown.
//  Then scans all players' latched counts for the one closest to trueCount.
//  Shows the result for a hold period, then pulses postSig to hand over to the post-game stage.
// PARAMETERS
//  NUM_PLAYERS  2   players compared, 1..9
//  COUNT_W      8   width of each count and of trueCount
//  ANSWER_SECS  10  countdown length in Clk1Hz ticks, 1..99
//  REVEAL_SECS  5   result hold length in Clk1Hz ticks, 1..255
// PORTS
//  Clk100M     in   1                     system clock, all logic on posedge
//  Rst_n       in   1                     asynchronous active-low reset
//  Clk1Hz      in   1                     one-Clk100M-cycle seconds strobe (not a clock)
//  answerSig   in   1                     start pulse, honoured only in IDLE
//  userCount   in   NUM_PLAYERS*COUNT_W   packed counts, player p = [p*COUNT_W +: COUNT_W]
//  trueCount   in   COUNT_W               correct answer
//  postSig     out  1                     one-cycle pulse at end of reveal
//  stopCount   out  1                     high from ANSWER entry until POST, inclusive
//  winnerIdx   out  4                     winning player index (0-based), valid in REVEAL/POST
//  winnerDiff  out  COUNT_W               |count - trueCount| of winner
//  tie         out  1                     another player had equal diff to winner
//  answerSeg0..3 out 8 each               7-seg, active-low {dp,g,f,e,d,c,b,a}; Seg0 rightmost
// BEHAVIOUR
//  Reset (async, Rst_n=0): state IDLE, counters 0.
//   Outputs: postSig=0, stopCount=0, winnerIdx=0, winnerDiff=0, tie=0, all segs 8'hFF (blank).
//  Glyphs: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 blank=FF dash=BF.
//  FSM states: IDLE -> ANSWER -> COMPARE -> REVEAL -> POST -> IDLE.
//  IDLE:
//   - answerSig=1 latches userCount and trueCount, loads remaining=ANSWER_SECS, enters ANSWER.
//   - stopCount=1 from the next cycle.
//   - A Clk1Hz tick in the same cycle is ignored.
//  ANSWER: Seg3/Seg2 = dash; Seg1/Seg0 = tens/ones of remaining.
//   - On Clk1Hz with remaining>1: remaining decrements.
//   - On Clk1Hz with remaining==1: remaining=0 and state goes to COMPARE.
//   - answerSig is ignored; the latched values are used, not live inputs.
//  COMPARE: one player per cycle, p=0..NUM_PLAYERS-1, so NUM_PLAYERS cycles.
//   - diff = |cnt_p - trueCount|, computed at COUNT_W bits; no overflow possible.
//   - A strictly smaller diff replaces the winner (lowest index wins ties).
//   - An equal diff sets tie.
//   - Clk1Hz is ignored. Segs show dash x4.
//  REVEAL: winnerIdx/winnerDiff/tie become stable on entry.
//   - Seg3 = digit (winnerIdx+1); Seg2..Seg0 = hundreds/tens/ones of winner's count (mod 1000).
//   - Seg3 dp lit (bit7=0) when tie=1.
//   - Counts REVEAL_SECS Clk1Hz ticks from entry; on the last tick goes to POST.
//  POST: exactly one cycle, postSig=1 and stopCount=1; next cycle IDLE.
//   - In IDLE: stopCount=0, segs blank, winner outputs hold until the next answerSig.
//  Mid-operation Rst_n low: immediate return to reset values; no postSig is emitted.
//  Latency:
//   - answerSig to stopCount: 1 cycle.
//   - Final ANSWER tick to REVEAL: NUM_PLAYERS+1 cycles.
// TESTING
//  T1 reset: Rst_n=0 mid-ANSWER -> same cycle stopCount=0, segs FF, postSig never pulses.
//  T2 countdown: ANSWER_SECS=10, answerSig -> Seg1/Seg0 = F9,C0 (10), then C0,90 (9) after the
//     1st tick, ..., COMPARE after the 10th tick.
//  T3 winner: NUM_PLAYERS=3, counts {12,9,15}, trueCount=10 -> winnerIdx=1, diff=1, tie=0,
//     Seg3=A4, Seg2..0 = C0,C0,90.
//  T4 tie: counts {8,12}, trueCount=10 -> winnerIdx=0, diff=2, tie=1, Seg3=79 (dp lit).
//  T5 edges: count 0 vs trueCount 255 -> diff=255.
//     answerSig during ANSWER -> ignored.
//     answerSig+Clk1Hz in the same IDLE cycle -> full countdown.
//  T6 handover: REVEAL_SECS=2 -> exactly one postSig cycle after the 2nd reveal tick.
//     stopCount falls the next cycle; a fresh answerSig restarts cleanly.

Source files
------------

// File: rtl/answer_period_mp.sv
// Multi-player answer window: freezes player counters, shows a seconds countdown,
// scans the latched counts for the one closest to trueCount, reveals it, then pulses postSig.
module answer_period_mp #(
  parameter int NUM_PLAYERS = 2,
  parameter int COUNT_W     = 8,
  parameter int ANSWER_SECS = 10,
  parameter int REVEAL_SECS = 5
) (
  input  logic                           Clk100M,
  input  logic                           Rst_n,
  input  logic                           Clk1Hz,
  input  logic                           answerSig,
  input  logic [NUM_PLAYERS*COUNT_W-1:0] userCount,
  input  logic [COUNT_W-1:0]             trueCount,
  output logic                           postSig,
  output logic                           stopCount,
  output logic [3:0]                     winnerIdx,
  output logic [COUNT_W-1:0]             winnerDiff,
  output logic                           tie,
  output logic [7:0]                     answerSeg0,
  output logic [7:0]                     answerSeg1,
  output logic [7:0]                     answerSeg2,
  output logic [7:0]                     answerSeg3
);

  typedef enum logic [2:0] {S_IDLE, S_ANSWER, S_COMPARE, S_REVEAL, S_POST} state_e;

  localparam logic [3:0] LAST_PLAYER = 4'(NUM_PLAYERS - 1);
  localparam logic [7:0] REVEAL_LAST = 8'(REVEAL_SECS - 1);
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_DASH    = 8'hBF;

  state_e                           state_q;
  logic [NUM_PLAYERS*COUNT_W-1:0]   cnt_q;
  logic [COUNT_W-1:0]               true_q;
  logic [6:0]                       remaining_q;
  logic [7:0]                       reveal_q;
  logic [3:0]                       scan_q;
  logic [3:0]                       best_idx_q,  best_idx_d;
  logic [COUNT_W-1:0]               best_diff_q, best_diff_d;
  logic [COUNT_W-1:0]               best_cnt_q,  best_cnt_d;
  logic                             best_tie_q,  best_tie_d;
  logic [3:0]                       win_idx_q;
  logic [COUNT_W-1:0]               win_diff_q;
  logic [COUNT_W-1:0]               win_cnt_q;
  logic                             win_tie_q;
  logic                             post_q;
  logic                             stop_q;
  logic [COUNT_W-1:0]               cur_cnt;
  logic [COUNT_W-1:0]               cur_diff;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] dec_digit(input logic [COUNT_W-1:0] v, input int unsigned div);
    int unsigned vv;
    vv = 32'(v);
    return 4'((vv / div) % 32'd10);
  endfunction

  // One player per cycle: player 0 seeds the running best, later players only win on a strictly smaller diff
  always_comb begin
    cur_cnt     = cnt_q[int'(scan_q)*COUNT_W +: COUNT_W];
    cur_diff    = (cur_cnt >= true_q) ? (cur_cnt - true_q) : (true_q - cur_cnt);
    best_idx_d  = best_idx_q;
    best_diff_d = best_diff_q;
    best_cnt_d  = best_cnt_q;
    best_tie_d  = best_tie_q;
    if (scan_q == 4'd0 || cur_diff < best_diff_q) begin
      best_idx_d  = scan_q;
      best_diff_d = cur_diff;
      best_cnt_d  = cur_cnt;
      best_tie_d  = 1'b0;
    end else if (cur_diff == best_diff_q) begin
      best_tie_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      true_q      <= '0;
      remaining_q <= '0;
      reveal_q    <= '0;
      scan_q      <= '0;
      best_idx_q  <= '0;
      best_diff_q <= '0;
      best_cnt_q  <= '0;
      best_tie_q  <= 1'b0;
      win_idx_q   <= '0;
      win_diff_q  <= '0;
      win_cnt_q   <= '0;
      win_tie_q   <= 1'b0;
      post_q      <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      post_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (answerSig) begin
            cnt_q       <= userCount;
            true_q      <= trueCount;
            remaining_q <= 7'(ANSWER_SECS);
            stop_q      <= 1'b1;
            state_q     <= S_ANSWER;
          end
        end
        S_ANSWER: begin
          if (Clk1Hz) begin
            if (remaining_q > 7'd1) begin
              remaining_q <= remaining_q - 7'd1;
            end else begin
              remaining_q <= '0;
              scan_q      <= '0;
              state_q     <= S_COMPARE;
            end
          end
        end
        S_COMPARE: begin
          best_idx_q  <= best_idx_d;
          best_diff_q <= best_diff_d;
          best_cnt_q  <= best_cnt_d;
          best_tie_q  <= best_tie_d;
          if (scan_q == LAST_PLAYER) begin
            win_idx_q  <= best_idx_d;
            win_diff_q <= best_diff_d;
            win_cnt_q  <= best_cnt_d;
            win_tie_q  <= best_tie_d;
            reveal_q   <= '0;
            state_q    <= S_REVEAL;
          end else begin
            scan_q <= scan_q + 4'd1;
          end
        end
        S_REVEAL: begin
          if (Clk1Hz) begin
            if (reveal_q == REVEAL_LAST) begin
              post_q  <= 1'b1;
              state_q <= S_POST;
            end else begin
              reveal_q <= reveal_q + 8'd1;
            end
          end
        end
        S_POST: begin
          stop_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Display decode from registered state; the winner stays on screen through POST
  always_comb begin
    answerSeg3 = SEG_BLANK;
    answerSeg2 = SEG_BLANK;
    answerSeg1 = SEG_BLANK;
    answerSeg0 = SEG_BLANK;
    case (state_q)
      S_ANSWER: begin
        answerSeg3 = SEG_DASH;
        answerSeg2 = SEG_DASH;
        answerSeg1 = glyph(4'(remaining_q / 7'd10));
        answerSeg0 = glyph(4'(remaining_q % 7'd10));
      end
      S_COMPARE: begin
        answerSeg3 = SEG_DASH;
        answerSeg2 = SEG_DASH;
        answerSeg1 = SEG_DASH;
        answerSeg0 = SEG_DASH;
      end
      S_REVEAL, S_POST: begin
        answerSeg3 = glyph(win_idx_q + 4'd1) & {~win_tie_q, 7'h7F};
        answerSeg2 = glyph(dec_digit(win_cnt_q, 32'd100));
        answerSeg1 = glyph(dec_digit(win_cnt_q, 32'd10));
        answerSeg0 = glyph(dec_digit(win_cnt_q, 32'd1));
      end
      default: ;
    endcase
  end

  assign postSig    = post_q;
  assign stopCount  = stop_q;
  assign winnerIdx  = win_idx_q;
  assign winnerDiff = win_diff_q;
  assign tie        = win_tie_q;

endmodule

// File: tb/tb_answer_period_mp.sv
// Directed-plus-random bench for answer_period_mp with a list-based closest-guess reference model.
module tb_answer_period_mp;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int AS = 10;
  localparam int RS = 2;

  logic           Clk100M = 1'b0;
  logic           Rst_n = 1'b0;
  logic           Clk1Hz = 1'b0;
  logic           answerSig = 1'b0;
  logic [N*W-1:0] userCount = '0;
  logic [W-1:0]   trueCount = '0;
  logic           postSig, stopCount, tie;
  logic [3:0]     winnerIdx;
  logic [W-1:0]   winnerDiff;
  logic [7:0]     answerSeg0, answerSeg1, answerSeg2, answerSeg3;

  int checks = 0;
  int errors = 0;
  int cnt_m[N];
  int true_m;
  int exp_idx, exp_diff;
  bit exp_tie;
  logic [7:0] GL[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [7:0] DASH  = 8'hBF;
  localparam logic [7:0] BLANK = 8'hFF;

  answer_period_mp #(.NUM_PLAYERS(N), .COUNT_W(W), .ANSWER_SECS(AS), .REVEAL_SECS(RS)) dut (
    .Clk100M(Clk100M), .Rst_n(Rst_n), .Clk1Hz(Clk1Hz), .answerSig(answerSig),
    .userCount(userCount), .trueCount(trueCount), .postSig(postSig), .stopCount(stopCount),
    .winnerIdx(winnerIdx), .winnerDiff(winnerDiff), .tie(tie),
    .answerSeg0(answerSeg0), .answerSeg1(answerSeg1), .answerSeg2(answerSeg2), .answerSeg3(answerSeg3)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_segs(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                          input logic [7:0] s1, input logic [7:0] s0);
    chk({tag, ".seg3"}, 32'(answerSeg3), 32'(s3));
    chk({tag, ".seg2"}, 32'(answerSeg2), 32'(s2));
    chk({tag, ".seg1"}, 32'(answerSeg1), 32'(s1));
    chk({tag, ".seg0"}, 32'(answerSeg0), 32'(s0));
  endtask

  task automatic cyc();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic sec();
    Clk1Hz = 1'b1;
    cyc();
    Clk1Hz = 1'b0;
  endtask

  task automatic scramble();
    for (int p = 0; p < N; p++) userCount[p*W +: W] = W'($urandom);
    trueCount = W'($urandom);
  endtask

  task automatic chk_countdown(input string tag, input int rem);
    chk_segs(tag, DASH, DASH, GL[rem / 10], GL[rem % 10]);
  endtask

  // Reference: list of distances, smallest wins with lowest index, tie when the minimum occurs twice
  task automatic model();
    int d[N];
    int best;
    int hits;
    best = -1;
    exp_idx = 0;
    for (int p = 0; p < N; p++) begin
      d[p] = (cnt_m[p] > true_m) ? cnt_m[p] - true_m : true_m - cnt_m[p];
      if (best < 0 || d[p] < best) begin
        best = d[p];
        exp_idx = p;
      end
    end
    hits = 0;
    for (int p = 0; p < N; p++) if (d[p] == best) hits++;
    exp_diff = best;
    exp_tie = (hits > 1);
  endtask

  task automatic play(input string tag, input bit tick_at_start, input bit poke);
    int c;
    logic [7:0] s3;
    for (int p = 0; p < N; p++) userCount[p*W +: W] = W'(cnt_m[p]);
    trueCount = W'(true_m);
    chk({tag, ".idle_stop"}, 32'(stopCount), 32'd0);
    chk_segs({tag, ".idle"}, BLANK, BLANK, BLANK, BLANK);
    answerSig = 1'b1;
    Clk1Hz = tick_at_start;
    cyc();
    answerSig = 1'b0;
    Clk1Hz = 1'b0;
    scramble();
    chk({tag, ".stop_on"}, 32'(stopCount), 32'd1);
    chk_countdown({tag, ".cd_start"}, AS);
    for (int k = 1; k <= AS; k++) begin
      repeat ($urandom_range(0, 2)) cyc();
      if (poke && k == 4) begin
        answerSig = 1'b1;
        scramble();
        cyc();
        answerSig = 1'b0;
        chk_countdown({tag, ".cd_poke"}, AS - 3);
      end
      sec();
      if (k < AS) chk_countdown({tag, ".cd"}, AS - k);
      else chk_segs({tag, ".cmp_entry"}, DASH, DASH, DASH, DASH);
    end
    model();
    for (int i = 1; i < N; i++) begin
      cyc();
      chk({tag, ".cmp_hold"}, 32'(answerSeg3), 32'(DASH));
    end
    cyc();
    c = cnt_m[exp_idx] % 1000;
    s3 = GL[exp_idx + 1] & (exp_tie ? 8'h7F : 8'hFF);
    chk({tag, ".winIdx"}, 32'(winnerIdx), 32'(exp_idx));
    chk({tag, ".winDiff"}, 32'(winnerDiff), 32'(exp_diff));
    chk({tag, ".tie"}, 32'(tie), 32'(exp_tie));
    chk_segs({tag, ".reveal"}, s3, GL[c / 100], GL[(c / 10) % 10], GL[c % 10]);
    chk({tag, ".reveal_post"}, 32'(postSig), 32'd0);
    for (int i = 1; i < RS; i++) begin
      sec();
      chk({tag, ".reveal_tick_post"}, 32'(postSig), 32'd0);
    end
    sec();
    chk({tag, ".post"}, 32'(postSig), 32'd1);
    chk({tag, ".post_stop"}, 32'(stopCount), 32'd1);
    cyc();
    chk({tag, ".after_post"}, 32'(postSig), 32'd0);
    chk({tag, ".after_stop"}, 32'(stopCount), 32'd0);
    chk_segs({tag, ".after"}, BLANK, BLANK, BLANK, BLANK);
    chk({tag, ".hold_idx"}, 32'(winnerIdx), 32'(exp_idx));
    chk({tag, ".hold_diff"}, 32'(winnerDiff), 32'(exp_diff));
  endtask

  initial begin
    Rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst.post", 32'(postSig), 32'd0);
    chk("rst.stop", 32'(stopCount), 32'd0);
    chk("rst.idx", 32'(winnerIdx), 32'd0);
    chk("rst.diff", 32'(winnerDiff), 32'd0);
    chk("rst.tie", 32'(tie), 32'd0);
    chk_segs("rst", BLANK, BLANK, BLANK, BLANK);
    Rst_n = 1'b1;
    cyc();

    cnt_m = '{12, 9, 15};
    true_m = 10;
    play("closest", 1'b1, 1'b1);

    cnt_m = '{8, 12, 200};
    true_m = 10;
    play("tie", 1'b0, 1'b0);

    cnt_m = '{0, 0, 0};
    true_m = 255;
    play("maxdiff", 1'b0, 1'b1);

    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < N; p++) cnt_m[p] = $urandom_range(0, 255);
      true_m = $urandom_range(0, 255);
      play("random", g[0], g[1]);
    end

    cnt_m = '{50, 60, 70};
    true_m = 65;
    for (int p = 0; p < N; p++) userCount[p*W +: W] = W'(cnt_m[p]);
    trueCount = W'(true_m);
    answerSig = 1'b1;
    cyc();
    answerSig = 1'b0;
    sec();
    sec();
    sec();
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midrst.stop", 32'(stopCount), 32'd0);
    chk("midrst.post", 32'(postSig), 32'd0);
    chk("midrst.idx", 32'(winnerIdx), 32'd0);
    chk("midrst.diff", 32'(winnerDiff), 32'd0);
    chk("midrst.tie", 32'(tie), 32'd0);
    chk_segs("midrst", BLANK, BLANK, BLANK, BLANK);
    cyc();
    Rst_n = 1'b1;
    for (int i = 0; i < AS + RS + 4; i++) begin
      sec();
      chk("midrst.quiet_post", 32'(postSig), 32'd0);
      chk("midrst.quiet_stop", 32'(stopCount), 32'd0);
    end

    cnt_m = '{50, 60, 70};
    true_m = 65;
    play("restart", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
